// File: rtl/yazmac_obegi_param.sv
// Integer register file: NREAD combinational read ports, one write port, hardwired x0,
// optional same-cycle write bypass, and a sequential sweep that zeroes the array.
module yazmac_obegi_param #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic [NREAD*AW-1:0]     rd_adr_i,
    output logic [NREAD*XLEN-1:0]   rd_data_o,
    input  logic                    wr_en_i,
    input  logic [AW-1:0]           wr_adr_i,
    input  logic [XLEN-1:0]         wr_data_i,
    output logic                    ready_o,
    output logic [AW-1:0]           clr_idx_o
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam logic [AW-1:0] IDX_FIRST = AW'(1);
    localparam logic [AW-1:0] IDX_LAST  = AW'(NREGS - 1);

    state_t          state_q;
    logic [AW-1:0]   idx_q;

    // x0 is never stored, so the array starts at index 1.
    logic [XLEN-1:0] reg_q [1:NREGS-1];

    logic            clearing;
    logic            arr_we;
    logic [AW-1:0]   arr_adr;
    logic [XLEN-1:0] arr_wdata;

    assign clearing = (state_q == ST_CLEAR);

    // The sweep and the user write share one array write port; reset blocks both.
    always_comb begin
        arr_we    = 1'b0;
        arr_adr   = wr_adr_i;
        arr_wdata = wr_data_i;
        if (!rst) begin
            if (clearing) begin
                arr_we    = 1'b1;
                arr_adr   = idx_q;
                arr_wdata = '0;
            end else if (wr_en_i && (wr_adr_i != '0)) begin
                arr_we    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            reg_q[arr_adr] <= arr_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            idx_q   <= IDX_FIRST;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (idx_q == IDX_LAST) begin
                        state_q <= ST_IDLE;
                        idx_q   <= IDX_FIRST;
                    end else begin
                        idx_q   <= idx_q + AW'(1);
                    end
                end
                ST_IDLE: begin
                    if (clr_i) begin
                        state_q <= ST_CLEAR;
                        idx_q   <= IDX_FIRST;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    idx_q   <= IDX_FIRST;
                end
            endcase
        end
    end

    assign ready_o   = (state_q == ST_IDLE);
    assign clr_idx_o = idx_q;

    genvar gi;
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_rd
            logic [AW-1:0]   adr;
            logic [XLEN-1:0] data;

            assign adr = rd_adr_i[gi*AW +: AW];

            // Priority: sweep in progress, x0, same-cycle write bypass, stored value.
            always_comb begin
                data = '0;
                if (!clearing && (adr != '0)) begin
                    if ((BYPASS != 0) && wr_en_i && (wr_adr_i == adr)) begin
                        data = wr_data_i;
                    end else begin
                        data = reg_q[adr];
                    end
                end
            end

            assign rd_data_o[gi*XLEN +: XLEN] = data;
        end
    endgenerate

endmodule

// File: tb/tb_yazmac_obegi_param.sv
// Bench for yazmac_obegi_param: bypass and non-bypass instances share stimulus and
// are checked against a register-file model, a vector table and directed sequences.
module tb_yazmac_obegi_param;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  clr_i;
    logic [NREAD*AW-1:0]   rd_adr_i;
    logic                  wr_en_i;
    logic [AW-1:0]         wr_adr_i;
    logic [XLEN-1:0]       wr_data_i;
    logic [NREAD*XLEN-1:0] rd_data_b, rd_data_n;
    logic                  ready_b, ready_n;
    logic [AW-1:0]         idx_b, idx_n;

    yazmac_obegi_param #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .clr_i(clr_i), .rd_adr_i(rd_adr_i), .rd_data_o(rd_data_b),
        .wr_en_i(wr_en_i), .wr_adr_i(wr_adr_i), .wr_data_i(wr_data_i),
        .ready_o(ready_b), .clr_idx_o(idx_b)
    );

    yazmac_obegi_param #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .clr_i(clr_i), .rd_adr_i(rd_adr_i), .rd_data_o(rd_data_n),
        .wr_en_i(wr_en_i), .wr_adr_i(wr_adr_i), .wr_data_i(wr_data_i),
        .ready_o(ready_n), .clr_idx_o(idx_n)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: architectural contents plus how many sweep edges are still owed.
    logic [XLEN-1:0] m_reg [NREGS];
    bit              m_clear;
    int              m_rem;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_read(input int p, input bit byp);
        int a;
        a = int'(rd_adr_i[p*AW +: AW]);
        if (m_clear || a == 0) return '0;
        if (byp && wr_en_i && int'(wr_adr_i) == a) return wr_data_i;
        return m_reg[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_clear = 1'b1;
            m_rem   = NREGS - 1;
        end else if (m_clear) begin
            m_reg[NREGS - m_rem] = '0;
            m_rem--;
            if (m_rem == 0) m_clear = 1'b0;
        end else begin
            if (wr_en_i && wr_adr_i != 0) m_reg[wr_adr_i] = wr_data_i;
            if (clr_i) begin
                m_clear = 1'b1;
                m_rem   = NREGS - 1;
            end
        end
    endtask

    task automatic check_model();
        int eidx;
        eidx = m_clear ? (NREGS - m_rem) : 1;
        check("ready_b", {31'b0, ready_b}, {31'b0, !m_clear});
        check("ready_n", {31'b0, ready_n}, {31'b0, !m_clear});
        check("clr_idx_b", {27'b0, idx_b}, eidx);
        check("clr_idx_n", {27'b0, idx_n}, eidx);
        for (int p = 0; p < NREAD; p++) begin
            check($sformatf("rd_byp_p%0d", p), rd_data_b[p*XLEN +: XLEN], exp_read(p, 1'b1));
            check($sformatf("rd_nob_p%0d", p), rd_data_n[p*XLEN +: XLEN], exp_read(p, 1'b0));
        end
    endtask

    // Inputs are stable from 1 ns after an edge; check mid-cycle, then take the edge.
    task automatic cycle();
        #3;
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        clr_i = 0; wr_en_i = 0; wr_adr_i = '0; wr_data_i = '0; rd_adr_i = '0;
    endtask

    typedef struct {
        logic            wr_en;
        logic [AW-1:0]   wr_adr;
        logic [XLEN-1:0] wr_data;
        logic [AW-1:0]   ra0;
        logic [AW-1:0]   ra1;
        logic [XLEN-1:0] exp0;
        logic [XLEN-1:0] exp1;
        logic [XLEN-1:0] exp0_nob;
    } vec_t;

    vec_t vecs [9];

    task automatic count_sweep(input string name);
        int cnt;
        cnt = 0;
        while (!ready_b && cnt < 100) begin
            cycle();
            cnt++;
        end
        check(name, cnt, NREGS - 1);
        $display("sweep %s: %0d edges", name, cnt);
    endtask

    initial begin
        vecs[0] = '{1, 5, 32'hDEADBEEF, 5, 0, 32'hDEADBEEF, 0, 0};
        vecs[1] = '{0, 0, 0,            5, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF};
        vecs[2] = '{1, 0, 32'h12345678, 0, 0, 0, 0, 0};
        vecs[3] = '{0, 0, 0,            0, 5, 0, 32'hDEADBEEF, 0};
        vecs[4] = '{1, 7, 32'hA5A5A5A5, 7, 7, 32'hA5A5A5A5, 32'hA5A5A5A5, 0};
        vecs[5] = '{0, 0, 0,            7, 5, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5};
        vecs[6] = '{1, 7, 32'h11111111, 7, 7, 32'h11111111, 32'h11111111, 32'hA5A5A5A5};
        vecs[7] = '{0, 3, 32'hFFFFFFFF, 3, 7, 0, 32'h11111111, 0};
        vecs[8] = '{0, 0, 0,            3, 31, 0, 0, 0};

        for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
        m_clear = 1'b1;
        m_rem   = NREGS - 1;
        idle_inputs();
        rst = 1;
        @(posedge clk);
        model_edge();
        #1;
        check("reset_ready", {31'b0, ready_b}, 0);
        check("reset_idx", {27'b0, idx_b}, 1);
        rst = 0;
        count_sweep("after_reset");

        // Directed vectors on a freshly cleared file.
        for (int i = 0; i < 9; i++) begin
            wr_en_i = vecs[i].wr_en; wr_adr_i = vecs[i].wr_adr; wr_data_i = vecs[i].wr_data;
            rd_adr_i = {vecs[i].ra1, vecs[i].ra0};
            #3;
            check($sformatf("vec%0d_p0", i), rd_data_b[XLEN-1:0], vecs[i].exp0);
            check($sformatf("vec%0d_p1", i), rd_data_b[2*XLEN-1:XLEN], vecs[i].exp1);
            check($sformatf("vec%0d_nob_p0", i), rd_data_n[XLEN-1:0], vecs[i].exp0_nob);
            $display("vec %0d: rd0=0x%08h rd1=0x%08h nob0=0x%08h", i,
                     rd_data_b[XLEN-1:0], rd_data_b[2*XLEN-1:XLEN], rd_data_n[XLEN-1:0]);
            @(posedge clk);
            model_edge();
            #1;
        end
        idle_inputs();

        // Fill x1..x31 with their index, then clear while writes keep arriving.
        for (int a = 1; a < NREGS; a++) begin
            wr_en_i = 1; wr_adr_i = AW'(a); wr_data_i = a;
            cycle();
        end
        wr_en_i = 0; clr_i = 1;
        cycle();
        clr_i = 0;
        check("clr_ready_low", {31'b0, ready_b}, 0);
        wr_en_i = 1; wr_data_i = 32'hCAFEF00D;
        begin
            int cnt;
            cnt = 0;
            while (!ready_b && cnt < 100) begin
                wr_adr_i = AW'($urandom_range(1, NREGS - 1));
                cycle();
                cnt++;
            end
            check("clr_sweep_len", cnt, NREGS - 1);
            $display("sweep clr_pulse: %0d edges", cnt);
        end
        idle_inputs();
        for (int a = 0; a < NREGS; a++) begin
            rd_adr_i = {AW'(NREGS - 1 - a), AW'(a)};
            #3;
            check($sformatf("post_clr_x%0d", a), rd_data_b[XLEN-1:0], 0);
            check($sformatf("post_clr_n_x%0d", a), rd_data_n[2*XLEN-1:XLEN], 0);
            #1;
            @(posedge clk);
            model_edge();
            #1;
        end

        // Reset in the middle of a sweep restarts it from index 1.
        clr_i = 1;
        cycle();
        clr_i = 0;
        begin
            int guard;
            guard = 0;
            while (idx_b != 10 && guard < 40) begin
                cycle();
                guard++;
            end
            check("reach_idx10", {27'b0, idx_b}, 10);
        end
        rst = 1;
        cycle();
        rst = 0;
        check("midsweep_rst_idx", {27'b0, idx_b}, 1);
        count_sweep("mid_sweep_reset");

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            rst       = ($urandom_range(0, 499) == 0);
            clr_i     = ($urandom_range(0, 63) == 0);
            wr_en_i   = $urandom_range(0, 1);
            wr_adr_i  = AW'($urandom);
            wr_data_i = $urandom;
            if ($urandom_range(0, 3) == 0) rd_adr_i = {wr_adr_i, wr_adr_i};
            else rd_adr_i = NREAD*AW'($urandom);
            cycle();
        end
        idle_inputs();
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
